// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one add-with-carry unit among N_REQ requesters.
// Each accepted operation is held for ADD_LAT cycles before {co, sum} is returned with its owner id.
module adder_share_arb #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 2,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_ci,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_co
);

  localparam int CNTW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   ptr_nxt;
  logic             gnt_found;
  logic [CNTW-1:0]  cnt;
  logic             accept;
  logic             vld_p1;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             ci_p0;
  logic [IDW-1:0]   id_p0;

  function automatic logic [WIDTH:0] add_wc(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             ci);
    add_wc = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  endfunction

  // Circular search for the first valid requester starting at ptr.
  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt       = IDW'(idx);
        gnt_found = 1'b1;
      end
    end
  end

  assign accept    = (state == IDLE) && gnt_found && !rst;
  assign vld_p1    = (state == BUSY) && (cnt == '0);
  assign rsp_valid = (state == DONE);
  assign ptr_nxt   = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (vld_p1)    state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
      cnt <= CNTW'(ADD_LAT - 1);
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Stage p0: operand capture on the accept handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= req_a[int'(gnt)*WIDTH +: WIDTH];
      b_p0  <= req_b[int'(gnt)*WIDTH +: WIDTH];
      ci_p0 <= req_ci[gnt];
      id_p0 <= gnt;
    end
  end

  // Stage p1: result registered once the evaluation window has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id  <= '0;
      rsp_sum <= '0;
      rsp_co  <= 1'b0;
    end else if (vld_p1) begin
      {rsp_co, rsp_sum} <= add_wc(a_p0, b_p0, ci_p0);
      rsp_id            <= id_p0;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed and randomized bench for adder_share_arb against a timeline-based reference model.
module tb_adder_share_arb;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int L   = 2;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ci;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_co;

  int total = 0;
  int bad   = 0;

  // Reference model: an operation accepted at cycle k is presented from cycle k+L+1 until consumed.
  int m_ptr;
  bit m_busy;
  int m_acc;
  int cyc = 0;
  int p_id, p_sum, p_co;
  int s_id, s_sum, s_co;
  int g_log[$];
  int g_cyc[$];
  int r_log[$];

  adder_share_arb #(.N_REQ(N), .WIDTH(W), .ADD_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = 0;
    s_id   = 0;
    s_sum  = 0;
    s_co   = 0;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_ci[i]       = ci;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  // One clock cycle: compare DUT against the model, log observed handshakes, advance the model.
  task automatic tick();
    int g;
    int s;
    bit found;
    bit due;
    logic [N-1:0] er;
    #1;
    found = 0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(m_ptr + k) % N]) begin
        found = 1;
        g     = (m_ptr + k) % N;
      end
    end
    er = '0;
    if (!m_busy && found) er[g] = 1'b1;
    due = m_busy && (cyc >= m_acc + L + 1);
    if (m_busy && (cyc == m_acc + L + 1)) begin
      s_id  = p_id;
      s_sum = p_sum;
      s_co  = p_co;
    end
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, due);
    chk("rsp_id", rsp_id, s_id);
    chk("rsp_sum", rsp_sum, s_sum);
    chk("rsp_co", rsp_co, s_co);
    for (int k = 0; k < N; k++) begin
      if (req_ready[k] === 1'b1 && req_valid[k]) begin
        g_log.push_back(k);
        g_cyc.push_back(cyc);
      end
    end
    if (rsp_valid === 1'b1 && rsp_ready) r_log.push_back(int'(rsp_id));
    if (!m_busy && found) begin
      s      = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]) + int'(req_ci[g]);
      p_sum  = s % (1 << W);
      p_co   = s / (1 << W);
      p_id   = g;
      m_ptr  = (g + 1) % N;
      m_busy = 1;
      m_acc  = cyc;
    end else if (due && rsp_ready) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_co", rsp_co, 0);
    chk("rst_req_ready", req_ready, 0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_ready", req_ready, 0);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    #1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, rsp_valid, 1);
  endtask

  initial begin
    int exp2[5];
    int exp3[4];
    logic [IDW-1:0] snap_id;
    logic [W-1:0]   snap_sum;
    logic           snap_co;
    exp2 = '{0, 1, 2, 3, 0};
    exp3 = '{1, 3, 1, 3};
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ci    = '0;
    rsp_ready = 1'b1;
    do_reset();

    // single request and carry-out cases
    set_op(0, 4'hF, 4'h1, 1'b1);
    req_valid = 4'b0001;
    tick();
    set_op(0, 4'h7, 4'h8, 1'b1);
    wait_rsp("s1_wait");
    chk("s1_id", rsp_id, 0);
    chk("s1_sum", rsp_sum, 4'h1);
    chk("s1_co", rsp_co, 1);
    chk("s1_latency", cyc - g_cyc[$], 3);
    tick();
    wait_rsp("s1b_wait");
    chk("s1b_sum", rsp_sum, 4'h0);
    chk("s1b_co", rsp_co, 1);
    req_valid = '0;
    tick();
    set_op(1, 4'hF, 4'hF, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_rsp("s1c_wait");
    chk("s1c_sum", rsp_sum, 4'hF);
    chk("s1c_co", rsp_co, 1);
    tick();

    // all requesters contend
    do_reset();
    g_log.delete();
    g_cyc.delete();
    req_valid = 4'b1111;
    repeat (21) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    chk("s2_count", g_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk("s2_order", g_log[i], exp2[i]);
    for (int i = 1; i < 5; i++) chk("s2_gap", g_cyc[i] - g_cyc[i-1], 4);

    // fairness between requesters 1 and 3
    do_reset();
    g_log.delete();
    g_cyc.delete();
    req_valid = 4'b1010;
    repeat (17) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) chk("s3_order", g_log[i], exp3[i]);
    for (int i = 1; i < 4; i++) chk("s3_alternate", g_log[i] != g_log[i-1], 1);

    // response backpressure
    do_reset();
    rsp_ready = 1'b0;
    rand_ops();
    req_valid = 4'b0001;
    wait_rsp("s4_wait");
    snap_id  = rsp_id;
    snap_sum = rsp_sum;
    snap_co  = rsp_co;
    repeat (5) begin
      tick();
      chk("s4_valid", rsp_valid, 1);
      chk("s4_ready", req_ready, 0);
      chk("s4_id", rsp_id, snap_id);
      chk("s4_sum", rsp_sum, snap_sum);
      chk("s4_co", rsp_co, snap_co);
    end
    rsp_ready = 1'b1;
    tick();
    chk("s4_regrant", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    // reset during BUSY
    do_reset();
    g_log.delete();
    r_log.delete();
    rand_ops();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1111;
    do_reset();
    g_log.delete();
    tick();
    chk("s5_first_grant", g_log[0], 0);
    req_valid = '0;
    wait_rsp("s5_wait");
    chk("s5_id", rsp_id, 0);
    tick();
    chk("s5_rsp_count", r_log.size(), 1);
    chk("s5_rsp_owner", r_log[0], 0);

    // withdrawn request
    do_reset();
    g_log.delete();
    r_log.delete();
    rand_ops();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0100;
    tick();
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("s6_grants", g_log.size(), 1);
    chk("s6_grant_id", g_log[0], 0);
    chk("s6_rsps", r_log.size(), 1);

    // randomized traffic
    do_reset();
    r_log.delete();
    repeat (300) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(3, 0) != 0);
      rand_ops();
      tick();
    end
    chk("rand_progress", r_log.size() > 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one WIDTH-bit add-with-carry unit among N_REQ requesters. Each requester presents operands with a valid/ready handshake. The block accepts one operation at a time and holds it for a fixed ADD_LAT-cycle evaluation window, which models the settling delay of the shared adder. It then returns {co, sum} with the requester ID over a single response channel. It sits between the operand-producing blocks and the shared adder datapath.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 4: operand and sum width.
- ADD_LAT, 2: evaluation cycles per operation (≥1).
- IDW, derived: max(1, clog2(N_REQ)).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B; same packing.
- req_ci  in  N_REQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  sum bits.
- rsp_co  out  1  carry-out.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE:**
  - Grant g is the first i with req_valid[i] set, searching circularly from ptr.
  - req_ready[g] = 1 combinationally; all other bits are 0. If no req_valid bit is set, all bits are 0.
  - On the handshake (req_valid[g] & req_ready[g]):
    - Capture a, b, ci and id = g.
    - ptr <= (g+1) mod N_REQ.
    - cnt <= ADD_LAT-1.
    - Next state is BUSY.
- **BUSY:**
  - req_ready = 0.
  - If cnt == 0:
    - Register {rsp_co, rsp_sum} <= a + b + ci, computed at WIDTH+1 bits with no truncation before the carry.
    - Register rsp_id <= id.
    - Next state is DONE.
  - Otherwise cnt <= cnt-1.
- **DONE:**
  - rsp_valid = 1 and req_ready = 0.
  - rsp_id, rsp_sum and rsp_co stay stable until the response handshake.
  - On rsp_valid & rsp_ready, next state is IDLE.
- req_valid may drop without a handshake. Arbitration is re-evaluated every IDLE cycle, and no grant is sticky.
- Operand inputs are ignored outside the IDLE handshake cycle.
- Round-robin order: the requester just served has the lowest priority at the next arbitration.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, cnt = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_co = 0.
  - req_ready = 0 while rst is high.
- Latency (accept handshake in cycle k):
  - BUSY occupies cycles k+1 .. k+ADD_LAT.
  - rsp_valid rises in cycle k+ADD_LAT+1.
- With rsp_ready held high, the next accept happens at the earliest in cycle k+ADD_LAT+2. Peak throughput is therefore one operation per ADD_LAT+2 cycles.
- Carry-out examples:
  - a=4'hF, b=4'h0, ci=1 gives sum=4'h0, co=1.
  - a=4'hF, b=4'hF, ci=1 gives sum=4'hF, co=1.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others wait with no loss of data, provided they hold req_valid and their operands.
- rsp_ready stuck low: the block stays in DONE indefinitely with all outputs stable and req_ready = 0.
- Reset asserted mid-BUSY or mid-DONE:
  - All state returns to reset values immediately (asynchronous).
  - The in-flight result is discarded and never presented.
  - ptr returns to 0.
- Reset release: arbitration may grant in the first cycle after rst deasserts.

## Test plan
Configuration for all scenarios: N_REQ=4, WIDTH=4, ADD_LAT=2.

1. **Single request.** After reset, req_valid=4'b0001, a=4'hF, b=4'h1, ci=1, accepted in cycle k -> rsp_valid high in cycle k+3 with rsp_id=0, rsp_sum=4'h1, rsp_co=1. Follow with a=7, b=8, ci=1 -> rsp_sum=4'h0, rsp_co=1.
2. **All requesters contend.** req_valid=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Accepts are spaced 4 cycles apart. Each sum matches that requester's operands.
3. **Fairness.** Only req_valid[1] and req_valid[3] held high -> grants alternate 1,3,1,3. Neither requester is granted twice in a row.
4. **Response backpressure.** rsp_ready=0 for 5 cycles while in DONE -> rsp_valid, rsp_id, rsp_sum and rsp_co are stable, and req_ready=4'b0000 throughout. When rsp_ready rises, the block returns to IDLE next cycle and grants again.
5. **Reset mid-operation.** Accept requester 2, then pulse rst during BUSY -> rsp_valid never asserts for that operation, and all outputs are 0 during reset. After release with req_valid=4'b1111, the first grant is requester 0.
6. **Withdrawn request.** req_valid[2] raised, then dropped before a grant while requester 0 is being served -> requester 2 is never granted and no spurious response appears.
